// File: rtl/video_pattern_gen.sv
// Raster timing generator with four test patterns (colour bars, gradient, checkerboard, solid).
// Counters walk the full blanking-inclusive raster; all outputs are registered one cycle behind.
module video_pattern_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_ACT = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  mode,
  input  logic [23:0] solid_color,
  output logic        activeVideo,
  output logic [23:0] videoData,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;
  localparam int unsigned BAR_W    = H_ACTIVE / 8;

  // Gradient and checker patterns index hcount[9:2] / hcount[5] / vcount[5], so keep those bits present.
  localparam int unsigned HW  = ($clog2(H_TOTAL) < 10) ? 10 : $clog2(H_TOTAL);
  localparam int unsigned VW  = ($clog2(V_TOTAL) < 6) ? 6 : $clog2(V_TOTAL);
  localparam int unsigned BPW = ($clog2(BAR_W) < 1) ? 1 : $clog2(BAR_W);

  localparam logic [1:0] MODE_BARS    = 2'd0;
  localparam logic [1:0] MODE_GRAD    = 2'd1;
  localparam logic [1:0] MODE_CHECKER = 2'd2;
  localparam logic [1:0] MODE_SOLID   = 2'd3;

  logic [HW-1:0]  hcount, hcount_n;
  logic [VW-1:0]  vcount, vcount_n;
  logic [BPW-1:0] bar_px, bar_px_n;
  logic [2:0]     bar_idx, bar_idx_n;
  logic [1:0]     mode_q, mode_q_n;
  logic [23:0]    color_q, color_q_n;

  logic           active_n;
  logic [23:0]    data_n;
  logic           hsync_n;
  logic           vsync_n;
  logic           frame_start_n;

  logic           first_px;
  logic           line_end;
  logic [1:0]     eff_mode;
  logic [23:0]    eff_color;
  logic [23:0]    pattern;
  logic [23:0]    bar_color;

  assign first_px = (hcount == '0) && (vcount == '0);
  assign line_end = (hcount == HW'(H_TOTAL - 1));

  // Settings sampled on the first pixel apply to that pixel already.
  assign eff_mode  = first_px ? mode        : mode_q;
  assign eff_color = first_px ? solid_color : color_q;

  // Raster position and bar tracking; everything collapses to zero while idle.
  always_comb begin
    hcount_n  = '0;
    vcount_n  = '0;
    bar_px_n  = '0;
    bar_idx_n = '0;
    mode_q_n  = mode_q;
    color_q_n = color_q;
    if (enable) begin
      if (first_px) begin
        mode_q_n  = mode;
        color_q_n = solid_color;
      end
      if (line_end) begin
        hcount_n = '0;
        vcount_n = (vcount == VW'(V_TOTAL - 1)) ? '0 : vcount + VW'(1);
      end else begin
        hcount_n = hcount + HW'(1);
        vcount_n = vcount;
        if (bar_px == BPW'(BAR_W - 1)) begin
          bar_px_n  = '0;
          bar_idx_n = bar_idx + 3'd1;
        end else begin
          bar_px_n  = bar_px + BPW'(1);
          bar_idx_n = bar_idx;
        end
      end
    end
  end

  // Colour bar palette, left to right.
  always_comb begin
    bar_color = 24'h000000;
    unique case (bar_idx)
      3'd0: bar_color = 24'hFFFFFF;
      3'd1: bar_color = 24'hFFFF00;
      3'd2: bar_color = 24'h00FFFF;
      3'd3: bar_color = 24'h00FF00;
      3'd4: bar_color = 24'hFF00FF;
      3'd5: bar_color = 24'hFF0000;
      3'd6: bar_color = 24'h0000FF;
      3'd7: bar_color = 24'h000000;
      default: bar_color = 24'h000000;
    endcase
  end

  // Pattern select.
  always_comb begin
    pattern = 24'h000000;
    unique case (eff_mode)
      MODE_BARS:    pattern = bar_color;
      MODE_GRAD:    pattern = {3{hcount[9:2]}};
      MODE_CHECKER: pattern = (hcount[5] ^ vcount[5]) ? 24'hFFFFFF : 24'h000000;
      MODE_SOLID:   pattern = eff_color;
      default:      pattern = 24'h000000;
    endcase
  end

  // Output next-values derived from the current counter state.
  always_comb begin
    active_n      = 1'b0;
    data_n        = 24'h000000;
    hsync_n       = ~SYNC_ACT;
    vsync_n       = ~SYNC_ACT;
    frame_start_n = 1'b0;
    if (enable) begin
      active_n      = (hcount < HW'(H_ACTIVE)) && (vcount < VW'(V_ACTIVE));
      data_n        = active_n ? pattern : 24'h000000;
      hsync_n       = ((hcount >= HW'(HS_START)) && (hcount < HW'(HS_END))) ? SYNC_ACT : ~SYNC_ACT;
      vsync_n       = ((vcount >= VW'(VS_START)) && (vcount < VW'(VS_END))) ? SYNC_ACT : ~SYNC_ACT;
      frame_start_n = first_px;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hcount      <= '0;
      vcount      <= '0;
      bar_px      <= '0;
      bar_idx     <= '0;
      mode_q      <= '0;
      color_q     <= '0;
      activeVideo <= 1'b0;
      videoData   <= 24'h000000;
      hsync       <= ~SYNC_ACT;
      vsync       <= ~SYNC_ACT;
      frame_start <= 1'b0;
    end else begin
      hcount      <= hcount_n;
      vcount      <= vcount_n;
      bar_px      <= bar_px_n;
      bar_idx     <= bar_idx_n;
      mode_q      <= mode_q_n;
      color_q     <= color_q_n;
      activeVideo <= active_n;
      videoData   <= data_n;
      hsync       <= hsync_n;
      vsync       <= vsync_n;
      frame_start <= frame_start_n;
    end
  end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Bench for video_pattern_gen on a shrunken raster (80x48) so several frames fit in a short run.
// A position-based reference model predicts every output cycle; spot tables and sequences cover corners.
module tb_video_pattern_gen;

  localparam int unsigned HA = 64, HFP = 4, HSW = 8, HBP = 4;
  localparam int unsigned VA = 40, VFP = 2, VSW = 3, VBP = 3;
  localparam bit SA = 1'b0;
  localparam int HT    = HA + HFP + HSW + HBP;
  localparam int VT    = VA + VFP + VSW + VBP;
  localparam int FRAME = HT * VT;
  localparam int BAR_W = HA / 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [1:0]  mode;
  logic [23:0] solid_color;
  logic        activeVideo;
  logic [23:0] videoData;
  logic        hsync, vsync, frame_start;

  video_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP), .SYNC_ACT(SA)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .solid_color(solid_color),
    .activeVideo(activeVideo), .videoData(videoData), .hsync(hsync), .vsync(vsync),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Model: linear position within the frame, plus the settings captured at frame start.
  int          m_pos = 0;
  int          m_h = 0, m_v = 0;
  logic [1:0]  m_mode = 2'd0;
  logic [23:0] m_color = 24'h0;
  logic [27:0] m_exp;

  typedef struct {
    logic [1:0]  md;
    logic [23:0] col;
    int          h;
    int          v;
    logic        av;
    logic        hs;
    logic        vs;
    logic [23:0] data;
  } vec_t;

  vec_t tbl [22];

  function automatic logic [27:0] idle_vec();
    return {1'b0, ~SA, ~SA, 1'b0, 24'h0};
  endfunction

  function automatic logic [23:0] pix(int h, int v, logic [1:0] m, logic [23:0] c);
    logic [7:0] g;
    case (m)
      2'd0: begin
        case (h / BAR_W)
          0: return 24'hFFFFFF;
          1: return 24'hFFFF00;
          2: return 24'h00FFFF;
          3: return 24'h00FF00;
          4: return 24'hFF00FF;
          5: return 24'hFF0000;
          6: return 24'h0000FF;
          default: return 24'h000000;
        endcase
      end
      2'd1: begin
        g = 8'((h / 4) % 256);
        return {g, g, g};
      end
      2'd2: return (((h / 32) % 2) != ((v / 32) % 2)) ? 24'hFFFFFF : 24'h000000;
      default: return c;
    endcase
  endfunction

  function automatic logic [27:0] model_out(int h, int v, logic [1:0] m, logic [23:0] c);
    logic av, hs, vs, fs;
    av = (h < HA) && (v < VA);
    hs = (h >= HA + HFP && h < HA + HFP + HSW) ? SA : ~SA;
    vs = (v >= VA + VFP && v < VA + VFP + VSW) ? SA : ~SA;
    fs = (h == 0) && (v == 0);
    return {av, hs, vs, fs, av ? pix(h, v, m, c) : 24'h0};
  endfunction

  task automatic model_reset();
    m_pos = 0; m_mode = 2'd0; m_color = 24'h0; m_exp = idle_vec();
  endtask

  task automatic model_edge();
    if (!rst) begin
      model_reset();
    end else if (!enable) begin
      m_pos = 0; m_exp = idle_vec();
    end else begin
      m_h = m_pos % HT;
      m_v = m_pos / HT;
      if (m_pos == 0) begin
        m_mode = mode; m_color = solid_color;
      end
      m_exp = model_out(m_h, m_v, m_mode, m_color);
      m_pos = (m_pos + 1) % FRAME;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // One clock: drive at the falling edge, model at the rising edge, compare at the next falling edge.
  task automatic step(input logic en, input logic [1:0] md, input logic [23:0] col);
    logic [27:0] got;
    enable = en; mode = md; solid_color = col;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    got = {activeVideo, hsync, vsync, frame_start, videoData};
    n_total++;
    if (got === m_exp) n_pass++;
    else $display("FAIL cycle h=%0d v=%0d: got %h expected %h", m_h, m_v, got, m_exp);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (3) step(1'b0, 2'd0, 24'h0);
    rst = 1'b1;
  endtask

  function automatic vec_t mk(logic [1:0] md, logic [23:0] col, int h, int v,
                              logic av, logic hs, logic vs, logic [23:0] d);
    vec_t r;
    r.md = md; r.col = col; r.h = h; r.v = v; r.av = av; r.hs = hs; r.vs = vs; r.data = d;
    return r;
  endfunction

  initial begin
    int fs_first, fs_second, hs_cnt, hs_first, vs_lines, vs_first, act_cnt, bad_cur, bad_next, p;
    logic [1:0]  rmode;
    logic [23:0] rcol;

    tbl[0]  = mk(2'd0, 24'h0,      0,  0, 1, 1, 1, 24'hFFFFFF);
    tbl[1]  = mk(2'd0, 24'h0,      7,  0, 1, 1, 1, 24'hFFFFFF);
    tbl[2]  = mk(2'd0, 24'h0,      8,  0, 1, 1, 1, 24'hFFFF00);
    tbl[3]  = mk(2'd0, 24'h0,     20,  3, 1, 1, 1, 24'h00FFFF);
    tbl[4]  = mk(2'd0, 24'h0,     63,  5, 1, 1, 1, 24'h000000);
    tbl[5]  = mk(2'd0, 24'h0,     40,  1, 1, 1, 1, 24'hFF0000);
    tbl[6]  = mk(2'd0, 24'h0,     64,  0, 0, 1, 1, 24'h000000);
    tbl[7]  = mk(2'd0, 24'h0,     68,  0, 0, 0, 1, 24'h000000);
    tbl[8]  = mk(2'd0, 24'h0,     75,  0, 0, 0, 1, 24'h000000);
    tbl[9]  = mk(2'd0, 24'h0,     76,  0, 0, 1, 1, 24'h000000);
    tbl[10] = mk(2'd2, 24'h0,     32,  0, 1, 1, 1, 24'hFFFFFF);
    tbl[11] = mk(2'd2, 24'h0,      0,  0, 1, 1, 1, 24'h000000);
    tbl[12] = mk(2'd2, 24'h0,     32, 32, 1, 1, 1, 24'h000000);
    tbl[13] = mk(2'd2, 24'h0,      0, 32, 1, 1, 1, 24'hFFFFFF);
    tbl[14] = mk(2'd1, 24'h0,     60,  1, 1, 1, 1, 24'h0F0F0F);
    tbl[15] = mk(2'd1, 24'h0,     44,  2, 1, 1, 1, 24'h0B0B0B);
    tbl[16] = mk(2'd3, 24'h123456, 10, 10, 1, 1, 1, 24'h123456);
    tbl[17] = mk(2'd0, 24'h0,      0, 42, 0, 1, 0, 24'h000000);
    tbl[18] = mk(2'd0, 24'h0,     70, 44, 0, 0, 0, 24'h000000);
    tbl[19] = mk(2'd0, 24'h0,      0, 45, 0, 1, 1, 24'h000000);
    tbl[20] = mk(2'd0, 24'h0,      0, 40, 0, 1, 1, 24'h000000);
    tbl[21] = mk(2'd0, 24'h0,     63, 39, 1, 1, 1, 24'h000000);

    rst = 1'b0; enable = 1'b0; mode = 2'd0; solid_color = 24'h0;
    model_reset();
    @(negedge clk);
    chk("reset_state", {28'h0, activeVideo, hsync, vsync, frame_start},
        {28'h0, 1'b0, ~SA, ~SA, 1'b0});
    chk("reset_data", {8'h0, videoData}, 32'h0);

    // Spot pixels, each from a fresh reset.
    for (int i = 0; i < 22; i++) begin
      do_reset();
      p = tbl[i].v * HT + tbl[i].h;
      repeat (p + 1) step(1'b1, tbl[i].md, tbl[i].col);
      chk($sformatf("tbl%0d_h%0d_v%0d", i, tbl[i].h, tbl[i].v),
          {5'h0, activeVideo, hsync, vsync, videoData},
          {5'h0, tbl[i].av, tbl[i].hs, tbl[i].vs, tbl[i].data});
    end

    // Frame period, hsync window and vsync lines over one full frame plus one cycle.
    do_reset();
    fs_first = -1; fs_second = -1; hs_cnt = 0; hs_first = -1;
    vs_lines = 0; vs_first = -1; act_cnt = 0;
    for (int k = 1; k <= FRAME + 1; k++) begin
      step(1'b1, 2'd0, 24'h0);
      if (frame_start) begin
        if (fs_first < 0) fs_first = k; else if (fs_second < 0) fs_second = k;
      end
      if (k - 1 < HT) begin
        if (hsync == SA) begin
          hs_cnt++;
          if (hs_first < 0) hs_first = k - 1;
        end
        if (activeVideo) act_cnt++;
      end
      if (k <= FRAME && (k - 1) % HT == 0 && vsync == SA) begin
        vs_lines++;
        if (vs_first < 0) vs_first = (k - 1) / HT;
      end
    end
    chk("fs_first_cycle", 32'(fs_first), 32'd1);
    chk("frame_period", 32'(fs_second - fs_first), 32'(FRAME));
    chk("hsync_len", 32'(hs_cnt), 32'(HSW));
    chk("hsync_start", 32'(hs_first), 32'(HA + HFP));
    chk("vsync_lines", 32'(vs_lines), 32'(VSW));
    chk("vsync_first_line", 32'(vs_first), 32'(VA + VFP));
    chk("active_per_line", 32'(act_cnt), 32'(HA));

    // Mode switch at line 10 must wait for the next frame.
    do_reset();
    bad_cur = 0; bad_next = 0;
    for (int k = 0; k < 2 * FRAME; k++) begin
      if (k < 10 * HT) step(1'b1, 2'd0, 24'h0);
      else             step(1'b1, 2'd3, 24'h123456);
      if (k >= 10 * HT && k < FRAME && activeVideo && (k % HT) < BAR_W && videoData != 24'hFFFFFF)
        bad_cur++;
      if (k >= FRAME && activeVideo && videoData != 24'h123456) bad_next++;
    end
    chk("switch_cur_frame_bars", 32'(bad_cur), 32'd0);
    chk("switch_next_frame_solid", 32'(bad_next), 32'd0);

    // Enable dropped mid-frame for 5 cycles.
    do_reset();
    repeat (20 * HT + 30) step(1'b1, 2'd0, 24'h0);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 2'd0, 24'h0);
      chk($sformatf("idle_%0d", k), {4'h0, activeVideo, hsync, vsync, frame_start, videoData},
          {4'h0, 1'b0, ~SA, ~SA, 1'b0, 24'h0});
    end
    step(1'b1, 2'd0, 24'h0);
    chk("restart_fs", {4'h0, activeVideo, hsync, vsync, frame_start, videoData},
        {4'h0, 1'b1, ~SA, ~SA, 1'b1, 24'hFFFFFF});

    // Asynchronous reset mid-line, once in active video and once inside hsync.
    for (int j = 0; j < 2; j++) begin
      do_reset();
      repeat ((j == 0) ? 6 : HT + 71) step(1'b1, 2'd0, 24'h0);
      #2 rst = 1'b0;
      #1;
      model_reset();
      chk($sformatf("async_rst_%0d", j), {4'h0, activeVideo, hsync, vsync, frame_start, videoData},
          {4'h0, 1'b0, ~SA, ~SA, 1'b0, 24'h0});
      step(1'b1, 2'd0, 24'h0);
      rst = 1'b1;
      step(1'b1, 2'd0, 24'h0);
      chk($sformatf("async_restart_%0d", j), {31'h0, frame_start}, 32'd1);
    end

    // Random mode/color changes and enable drops against the model.
    do_reset();
    rmode = 2'd0; rcol = 24'h0;
    for (int k = 0; k < 3 * FRAME; k++) begin
      if (m_pos == 0 && $urandom_range(1, 0) == 1) begin
        rmode = 2'($urandom_range(3, 0)); rcol = 24'($urandom);
      end else if ($urandom_range(499, 0) == 0) begin
        rmode = 2'($urandom_range(3, 0)); rcol = 24'($urandom);
      end
      if ($urandom_range(2999, 0) == 0) begin
        repeat ($urandom_range(6, 1)) step(1'b0, rmode, rcol);
      end
      step(1'b1, rmode, rcol);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
